// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcodes, instruction field ranges and operand-use helper for the core.
package cpu_pkg;
    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_SW  = 4'b1010;
    localparam logic [3:0] OP_BNE = 4'b1110;
    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam int RS_HI = 11;
    localparam int RS_LO = 8;
    localparam int RT_HI = 7;
    localparam int RT_LO = 4;
    localparam int RD_HI = 3;
    localparam int RD_LO = 0;
    // LW and unknown opcodes read rs only
    function automatic logic uses_rt(input logic [3:0] op);
        return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SW, OP_BNE};
    endfunction
endpackage

// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit: flags a load-use dependency between the LW in EX and the instruction in IF/ID.
module hazard_detect_unit
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    input  logic               if_id_valid,
    input  logic               id_ex_valid,
    input  logic               id_ex_mem_read,
    input  logic [3:0]         id_ex_rt,
    output logic               load_use
);
    logic [3:0] op, rs, rt;
    assign op = instr[OP_HI:OP_LO];
    assign rs = instr[RS_HI:RS_LO];
    assign rt = instr[RT_HI:RT_LO];
    assign load_use = if_id_valid & id_ex_valid & id_ex_mem_read & (id_ex_rt != 4'd0) &
                      ((id_ex_rt == rs) | (uses_rt(op) & (id_ex_rt == rt)));
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, IF/ID pipeline register and load-use stall control for the 16-bit core.
module fetch_stage #(
    parameter int             PC_W     = 16,
    parameter int             INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               ext_hold,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               id_ex_mem_read,
    input  logic               id_ex_valid,
    input  logic [3:0]         id_ex_rt,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc_plus1,
    output logic               if_id_valid,
    output logic               id_bubble,
    output logic               stall,
    output logic [15:0]        stall_count
);
    logic [PC_W-1:0] pc;
    logic            load_use;
    hazard_detect_unit u_hdu (
        .instr          (if_id_instr),
        .if_id_valid    (if_id_valid),
        .id_ex_valid    (id_ex_valid),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rt       (id_ex_rt),
        .load_use       (load_use)
    );
    assign imem_addr = pc;
    assign stall     = load_use & ~ext_hold;
    assign id_bubble = stall;
    // hold and stall both freeze the front end; branches resolve only when it moves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            if_id_instr    <= '0;
            if_id_pc_plus1 <= '0;
            if_id_valid    <= 1'b0;
        end else if (!ext_hold && !stall) begin
            if (branch_taken) begin
                pc             <= branch_target;
                if_id_instr    <= '0;
                if_id_pc_plus1 <= '0;
                if_id_valid    <= 1'b0;
            end else begin
                pc             <= pc + PC_W'(1);
                if_id_instr    <= imem_data;
                if_id_pc_plus1 <= pc + PC_W'(1);
                if_id_valid    <= 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (stall && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch, branch flush, load-use stall, hold, PC wrap and async reset.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] imem_addr, imem_data;
    logic        ext_hold, branch_taken, id_ex_mem_read, id_ex_valid;
    logic [15:0] branch_target;
    logic [3:0]  id_ex_rt;
    logic [15:0] if_id_instr, if_id_pc_plus1, stall_count;
    logic        if_id_valid, id_bubble, stall;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .ext_hold       (ext_hold),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_valid    (id_ex_valid),
        .id_ex_rt       (id_ex_rt),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus1 (if_id_pc_plus1),
        .if_id_valid    (if_id_valid),
        .id_bubble      (id_bubble),
        .stall          (stall),
        .stall_count    (stall_count)
    );

    function automatic logic [15:0] imem(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h2123;
            16'h0001: return 16'h6456;
            16'h0040: return 16'h2345;
            16'h0041: return 16'h8235;
            16'h0042: return 16'hA130;
            default:  return {4'h1, a[11:0]};
        endcase
    endfunction

    always_comb imem_data = imem(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag, input logic [15:0] addr, input logic [15:0] instr,
                              input logic [15:0] pc1, input logic valid);
        check({tag, ".imem_addr"}, 32'(imem_addr), 32'(addr));
        check({tag, ".instr"}, 32'(if_id_instr), 32'(instr));
        check({tag, ".pc_plus1"}, 32'(if_id_pc_plus1), 32'(pc1));
        check({tag, ".valid"}, 32'(if_id_valid), 32'(valid));
    endtask

    initial begin
        rst_n = 1'b0;
        ext_hold = 1'b0;
        branch_taken = 1'b0;
        branch_target = 16'h0;
        id_ex_mem_read = 1'b0;
        id_ex_valid = 1'b0;
        id_ex_rt = 4'd0;
        repeat (2) @(negedge clk);
        check_regs("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        check("reset.stall_count", 32'(stall_count), 32'd0);
        check("reset.stall", 32'(stall), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_regs("fetch0", 16'h0001, 16'h2123, 16'h0001, 1'b1);
        @(negedge clk);
        check_regs("fetch1", 16'h0002, 16'h6456, 16'h0002, 1'b1);
        branch_taken = 1'b1;
        branch_target = 16'h0040;
        @(negedge clk);
        check_regs("branch_flush", 16'h0040, 16'h0000, 16'h0000, 1'b0);
        branch_taken = 1'b0;
        @(negedge clk);
        check_regs("branch_fetch", 16'h0041, 16'h2345, 16'h0041, 1'b1);
        // LW rt=3 in EX against ADD rs=3, with a simultaneous branch that must be ignored
        id_ex_valid = 1'b1;
        id_ex_mem_read = 1'b1;
        id_ex_rt = 4'd3;
        branch_taken = 1'b1;
        branch_target = 16'h0080;
        #1;
        check("lu.stall", 32'(stall), 32'd1);
        check("lu.bubble", 32'(id_bubble), 32'd1);
        @(negedge clk);
        check_regs("lu_hold", 16'h0041, 16'h2345, 16'h0041, 1'b1);
        check("lu.stall_count", 32'(stall_count), 32'd1);
        branch_taken = 1'b0;
        id_ex_rt = 4'd0;
        #1;
        check("rt0.stall", 32'(stall), 32'd0);
        id_ex_rt = 4'd4;
        #1;
        check("rt_match_add.stall", 32'(stall), 32'd1);
        id_ex_rt = 4'd3;
        ext_hold = 1'b1;
        #1;
        check("hold.stall", 32'(stall), 32'd0);
        check("hold.bubble", 32'(id_bubble), 32'd0);
        @(negedge clk);
        check_regs("hold", 16'h0041, 16'h2345, 16'h0041, 1'b1);
        check("hold.stall_count", 32'(stall_count), 32'd1);
        ext_hold = 1'b0;
        id_ex_valid = 1'b0;
        #1;
        check("ex_invalid.stall", 32'(stall), 32'd0);
        @(negedge clk);
        check_regs("fetch41", 16'h0042, 16'h8235, 16'h0042, 1'b1);
        id_ex_valid = 1'b1;
        id_ex_rt = 4'd3;
        #1;
        check("lw_rt.stall", 32'(stall), 32'd0);
        id_ex_rt = 4'd2;
        #1;
        check("lw_rs.stall", 32'(stall), 32'd1);
        id_ex_valid = 1'b0;
        @(negedge clk);
        check_regs("fetch42", 16'h0043, 16'hA130, 16'h0043, 1'b1);
        id_ex_valid = 1'b1;
        id_ex_rt = 4'd3;
        #1;
        check("sw_rt.stall", 32'(stall), 32'd1);
        id_ex_mem_read = 1'b0;
        #1;
        check("not_load.stall", 32'(stall), 32'd0);
        id_ex_valid = 1'b0;
        branch_taken = 1'b1;
        branch_target = 16'hFFFF;
        @(negedge clk);
        check_regs("br_ffff", 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
        branch_taken = 1'b0;
        @(negedge clk);
        check_regs("wrap", 16'h0000, 16'h1FFF, 16'h0000, 1'b1);
        id_ex_valid = 1'b1;
        id_ex_mem_read = 1'b1;
        id_ex_rt = 4'd15;
        @(negedge clk);
        check("wrap_stall.stall", 32'(stall), 32'd1);
        check("wrap_stall.stall_count", 32'(stall_count), 32'd2);
        check_regs("wrap_stall", 16'h0000, 16'h1FFF, 16'h0000, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_regs("async_reset", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        check("async_reset.stall_count", 32'(stall_count), 32'd0);
        check("async_reset.stall", 32'(stall), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the 16-bit pipelined RISC core. Holds the PC, addresses the external instruction memory, and registers {instruction, PC+1, valid} for decode, whose opcode field drives control_unit. It also contains load-use hazard detection, which stalls fetch and requests a bubble into ID/EX.

Parameters:
PC_W, 16, PC width; word-addressed, +1 per instruction
INSTR_W, 16, instruction width
RESET_PC, 16'h0000, PC value after reset

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
imem_addr  out  PC_W  instruction memory address (= PC)
imem_data  in  INSTR_W  instruction at imem_addr, combinational read
ext_hold  in  1  global freeze (e.g. data-memory wait)
branch_taken  in  1  BNE resolved taken in ID
branch_target  in  PC_W  redirect address
id_ex_mem_read  in  1  instruction in EX is LW
id_ex_valid  in  1  EX slot holds a real instruction
id_ex_rt  in  4  LW destination register
if_id_instr  out  INSTR_W  registered instruction to decode
if_id_pc_plus1  out  PC_W  registered PC+1
if_id_valid  out  1  IF/ID slot holds a real instruction
id_bubble  out  1  force zero control into ID/EX this cycle
stall  out  1  load-use stall active
stall_count  out  16  saturating count of load-use stall cycles

Behaviour:
- Instruction fields: op[15:12], rs[11:8], rt[7:4], rd/imm[3:0]. Register 0 is hardwired zero.
- Reset (async, rst_n=0): PC=RESET_PC, if_id_instr=0, if_id_pc_plus1=0, if_id_valid=0, stall_count=0. Outputs take these values immediately on assertion, including mid-stall or mid-branch.
- imem_addr = PC, combinational. The first fetch after reset release is at RESET_PC.
- Load-use hazard (combinational): load_use = if_id_valid & id_ex_valid & id_ex_mem_read & (id_ex_rt != 0) & (id_ex_rt == rs | (uses_rt & id_ex_rt == rt)).
  - uses_rt = op in {AND, OR, ADD, SUB, SLT, SW, BNE}.
  - LW uses only rs.
  - Unknown opcodes use rs only.
- stall = load_use & ~ext_hold. id_bubble = stall.
- Per-edge update, in priority order:
  1. ext_hold=1: PC and IF/ID hold. branch_taken is ignored. stall_count does not increment.
  2. stall=1: PC and IF/ID hold. branch_taken is ignored; decode re-evaluates it next cycle. stall_count += 1, saturating at 16'hFFFF.
  3. branch_taken=1: PC <= branch_target. IF/ID flushed: instr=0, pc_plus1=0, valid=0.
  4. Otherwise: IF/ID <= {imem_data, PC+1, 1}. PC <= PC+1.
- PC arithmetic is modulo 2^PC_W: 16'hFFFF+1 = 16'h0000. if_id_pc_plus1 wraps the same way.
- Latency: the instruction at address A appears on if_id_instr 1 cycle after imem_addr=A, absent hold/stall/branch.
- A branch costs exactly one flushed slot. A load-use costs exactly one stall cycle, since the LW moves to MEM on the next edge.
- Decode must qualify all use of if_id_instr with if_id_valid. The flushed word 16'h0000 decodes as AND and must not be executed.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants: OP_AND=4'b0000, OP_OR=4'b0001, OP_ADD=4'b0010, OP_SUB=4'b0110, OP_SLT=4'b0111, OP_LW=4'b1000, OP_SW=4'b1010, OP_BNE=4'b1110
  - field bit ranges
  - PC_W and INSTR_W
  - the uses_rt function
- One natural sub-module: hazard_detect_unit (combinational load_use generation), reused later by forwarding work.
- PC register, IF/ID register, and stall counter stay in fetch_stage.

Test Plan:
- Reset then release, imem returning 16'h2123 at 0 and 16'h6456 at 1 -> imem_addr 0,1,2 on successive cycles; if_id_instr=2123/pc_plus1=1/valid=1, then 6456/2/1.
- branch_taken=1, target=16'h0040 with no stall -> next cycle imem_addr=0040, if_id_valid=0, if_id_instr=0; the following cycle fetches from 0040.
- id_ex LW rt=3 valid, IF/ID=ADD 16'h2345 (rs=3) -> stall=1, id_bubble=1, PC and IF/ID unchanged for one cycle, stall_count 0->1.
- Same case with id_ex_rt=0, or IF/ID=LW 16'h8235 (rt=3, rs=2) -> stall=0.
- Stall plus branch_taken in the same cycle -> branch ignored, PC held. ext_hold=1 with load_use -> stall=0, id_bubble=0, counter unchanged.
- PC=16'hFFFF normal fetch -> PC=0000 and if_id_pc_plus1=0000. Assert rst_n=0 mid-stall -> all outputs return to reset values without a clock edge.
